line_buffer_feeder: RTL and testbench

- Sequencer that sits directly upstream of the line-buffer column-pointer controller.
- Walks a feature map stored in single-port SRAM band by band. For each output band it fetches KER_SIZE vertically adjacent pixels per column and emits them as one column vector with a valid strobe.
- Generates the end-of-band strobe (row_done) and the frame-start flush that drive the column-pointer controller's valid, sram_row_is_done and flush inputs.

---
 rtl/line_buffer_feeder.sv | 198 +++++++++++++++++++
 tb/tb_line_buffer_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_feeder
// Function : Band-by-band SRAM walker emitting KER_SIZE-pixel column vectors
// Revision : 1.0
// ============================================================================
module line_buffer_feeder #(
    parameter int KER_SIZE = 3,
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          base_addr,
    output logic                       sram_re,
    output logic [ADDR_W-1:0]          sram_addr,
    input  logic [DATA_W-1:0]          sram_rdata,
    output logic                       col_valid,
    output logic [KER_SIZE*DATA_W-1:0] col_data,
    output logic                       row_done,
    output logic                       flush,
    output logic                       busy,
    output logic                       done
);

    localparam int c_k_w = $clog2(KER_SIZE);
    localparam int c_c_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_r_w = (IMG_H > KER_SIZE) ? $clog2(IMG_H - KER_SIZE + 1) : 1;

    localparam logic [c_k_w-1:0]  c_k_last   = c_k_w'(KER_SIZE - 1);
    localparam logic [c_c_w-1:0]  c_c_last   = c_c_w'(IMG_W - 1);
    localparam logic [c_r_w-1:0]  c_r_last   = c_r_w'(IMG_H - KER_SIZE);
    localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(IMG_W);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_flush  = 3'd1;
    localparam logic [2:0] c_st_read   = 3'd2;
    localparam logic [2:0] c_st_drain1 = 3'd3;
    localparam logic [2:0] c_st_drain2 = 3'd4;
    localparam logic [2:0] c_st_rowend = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    logic [2:0]                 state_q, state_d;
    logic [c_r_w-1:0]           r_q, r_d;
    logic [c_c_w-1:0]           c_q, c_d;
    logic [c_k_w-1:0]           k_q, k_d;
    logic [ADDR_W-1:0]          row_base_q, row_base_d;
    logic [ADDR_W-1:0]          col_base_q, col_base_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       rd_vld_q, rd_vld_d;
    logic [c_k_w-1:0]           rd_tag_q, rd_tag_d;
    logic                       col_valid_q, col_valid_d;
    logic [KER_SIZE*DATA_W-1:0] col_data_q, col_data_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       abort_hit;

    assign abort_hit = abort && (state_q != c_st_idle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:   if (start) state_d = c_st_flush;
            c_st_flush:  state_d = c_st_read;
            c_st_read:   if (k_q == c_k_last && c_q == c_c_last) state_d = c_st_drain1;
            c_st_drain1: state_d = c_st_drain2;
            c_st_drain2: state_d = c_st_rowend;
            c_st_rowend: state_d = (r_q == c_r_last) ? c_st_done : c_st_read;
            c_st_done:   state_d = c_st_idle;
            default:     state_d = c_st_idle;
        endcase
        if (abort_hit) begin
            state_d = c_st_idle;
        end
    end

    always_comb begin
        sram_re   = (state_q == c_st_read);
        sram_addr = (state_q == c_st_read) ? addr_q : '0;
        flush     = (state_q == c_st_flush) || flush_pend_q;
        busy      = (state_q == c_st_flush)  || (state_q == c_st_read) ||
                    (state_q == c_st_drain1) || (state_q == c_st_drain2) ||
                    (state_q == c_st_rowend);
        row_done  = (state_q == c_st_rowend);
        done      = (state_q == c_st_done);
    end

    assign col_valid = col_valid_q;
    assign col_data  = col_data_q;

    // Address walks down a column by row_step per tap, then hops to the next column base.
    always_comb begin
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        addr_d     = addr_q;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    r_d        = '0;
                    c_d        = '0;
                    k_d        = '0;
                    row_base_d = base_addr;
                    col_base_d = base_addr;
                    addr_d     = base_addr;
                end
            end
            c_st_read: begin
                if (k_q == c_k_last) begin
                    k_d = '0;
                    if (c_q != c_c_last) begin
                        c_d        = c_q + 1'b1;
                        col_base_d = col_base_q + 1'b1;
                        addr_d     = col_base_q + 1'b1;
                    end
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + c_row_step;
                end
            end
            c_st_rowend: begin
                if (r_q != c_r_last) begin
                    r_d        = r_q + 1'b1;
                    c_d        = '0;
                    k_d        = '0;
                    row_base_d = row_base_q + c_row_step;
                    col_base_d = row_base_q + c_row_step;
                    addr_d     = row_base_q + c_row_step;
                end
            end
            default: ;
        endcase
    end

    // Read tag travels one cycle behind the request, matching SRAM latency.
    always_comb begin
        rd_vld_d     = (state_q == c_st_read);
        rd_tag_d     = k_q;
        col_valid_d  = rd_vld_q && (rd_tag_q == c_k_last);
        col_data_d   = col_data_q;
        flush_pend_d = abort_hit;
        if (rd_vld_q) begin
            for (int i = 0; i < KER_SIZE; i++) begin
                if (rd_tag_q == c_k_w'(i)) begin
                    col_data_d[i*DATA_W +: DATA_W] = sram_rdata;
                end
            end
        end
        if (abort_hit) begin
            rd_vld_d    = 1'b0;
            col_valid_d = 1'b0;
            col_data_d  = col_data_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            row_base_q   <= '0;
            col_base_q   <= '0;
            addr_q       <= '0;
            rd_vld_q     <= 1'b0;
            rd_tag_q     <= '0;
            col_valid_q  <= 1'b0;
            col_data_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            k_q          <= k_d;
            row_base_q   <= row_base_d;
            col_base_q   <= col_base_d;
            addr_q       <= addr_d;
            rd_vld_q     <= rd_vld_d;
            rd_tag_q     <= rd_tag_d;
            col_valid_q  <= col_valid_d;
            col_data_q   <= col_data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_feeder
// Function : Randomized self-checking bench against a cycle-indexed frame model
// Revision : 1.0
// ============================================================================
module tb_line_buffer_feeder;

    localparam int K        = 3;
    localparam int DW       = 8;
    localparam int IW       = 4;
    localparam int IH       = 4;
    localparam int AW       = 8;
    localparam int NB       = IH - K + 1;
    localparam int P        = IW * K + 3;
    localparam int DONE_CYC = 1 + NB * P + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic            sram_re;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_rdata = '0;
    logic            col_valid;
    logic [K*DW-1:0] col_data;
    logic            row_done;
    logic            flush;
    logic            busy;
    logic            done;

    logic [DW-1:0]   mem [256];
    int              n_cmp = 0;
    int              n_mis = 0;

    line_buffer_feeder #(
        .KER_SIZE(K), .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .base_addr(base_addr), .sram_re(sram_re), .sram_addr(sram_addr),
        .sram_rdata(sram_rdata), .col_valid(col_valid), .col_data(col_data),
        .row_done(row_done), .flush(flush), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_now();
        return {flush, busy, sram_re, row_done, done, col_valid};
    endfunction

    // Expected outputs at cycle n after the start cycle, derived from the frame timeline.
    task automatic model(input int n, input logic [AW-1:0] base, output logic [5:0] ctrl,
                         output logic [AW-1:0] addr, output logic [K*DW-1:0] data);
        int b, o, c;
        ctrl = '0;
        addr = '0;
        data = '0;
        if (n >= 1 && n <= DONE_CYC) begin
            ctrl[5] = (n == 1);
            ctrl[4] = (n < DONE_CYC);
            ctrl[1] = (n == DONE_CYC);
            if (n >= 2 && n < DONE_CYC) begin
                b = (n - 2) / P;
                o = (n - 2) % P;
                if (o < IW * K) begin
                    ctrl[3] = 1'b1;
                    addr    = AW'(int'(base) + (b + o % K) * IW + o / K);
                end
                ctrl[2] = (o == IW * K + 2);
                if (o >= K + 1 && (o - K - 1) % K == 0 && (o - K - 1) / K < IW) begin
                    ctrl[0] = 1'b1;
                    c = (o - K - 1) / K;
                    for (int kk = 0; kk < K; kk++)
                        data[kk*DW +: DW] = mem[AW'(int'(base) + (b + kk) * IW + c)];
                end
            end
        end
    endtask

    // Called at a negedge in an idle cycle: that cycle becomes cycle 0 of the frame.
    task automatic run_frame(input logic [AW-1:0] base, input int abort_at, input int dup_at,
                             input int rst_at, input bit chk_first);
        int              ncv;
        int              nrd;
        logic [5:0]      ec;
        logic [AW-1:0]   ea;
        logic [K*DW-1:0] ed;
        ncv = 0;
        nrd = 0;
        base_addr = base;
        start     = 1'b1;
        for (int n = 1; n <= DONE_CYC + 1; n++) begin
            @(negedge clk);
            start     = (n == dup_at);
            base_addr = AW'($urandom);
            model(n, base, ec, ea, ed);
            check($sformatf("ctrl@%0d", n), 64'(ctrl_now()), 64'(ec));
            if (ec[3]) check($sformatf("addr@%0d", n), 64'(sram_addr), 64'(ea));
            if (ec[0]) check($sformatf("data@%0d", n), 64'(col_data), 64'(ed));
            if (chk_first && n == 6) check("first_col", 64'(col_data), 64'h181410);
            ncv += int'(col_valid);
            nrd += int'(row_done);
            if (n == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check($sformatf("abort_next@%0d", n + 1), 64'(ctrl_now()), 64'b100000);
                return;
            end
            if (n == rst_at) begin
                #2 rstn = 1'b0;
                #1;
                check("rst_ctrl", 64'(ctrl_now()), 64'd0);
                check("rst_addr", 64'(sram_addr), 64'd0);
                check("rst_data", 64'(col_data), 64'd0);
                @(negedge clk);
                check("rst_hold", 64'(ctrl_now()), 64'd0);
                rstn = 1'b1;
                return;
            end
        end
        check("n_col_valid", 64'(ncv), 64'(IW * NB));
        check("n_row_done", 64'(nrd), 64'(NB));
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    endtask

    function automatic int pick_read_cycle();
        return 2 + int'($urandom_range(0, NB - 1)) * P + int'($urandom_range(0, IW * K - 1));
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'(ctrl_now()), 64'd0);
        check("reset_addr", 64'(sram_addr), 64'd0);
        check("reset_data", 64'(col_data), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_ctrl", 64'(ctrl_now()), 64'd0);

        run_frame(8'h10, -1, -1, -1, 1'b1);

        fill_random();
        run_frame(8'hF8, -1, -1, -1, 1'b0);

        run_frame(AW'($urandom), -1, 10, -1, 1'b0);

        repeat (3) begin
            fill_random();
            run_frame(AW'($urandom), -1, -1, -1, 1'b0);
        end

        run_frame(AW'($urandom), pick_read_cycle(), -1, -1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_quiet", 64'(ctrl_now()), 64'd0);
        end

        repeat (2) begin
            run_frame(AW'($urandom), pick_read_cycle(), -1, -1, 1'b0);
            run_frame(AW'($urandom), -1, -1, -1, 1'b0);
        end

        run_frame(AW'($urandom), -1, -1, pick_read_cycle(), 1'b0);
        @(negedge clk);
        check("post_rst_idle", 64'(ctrl_now()), 64'd0);
        fill_random();
        run_frame(AW'($urandom), -1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
